// File: rtl/dot_sched.sv
// dot_sched: steps one dot product engine through LAYER0..LAYER3 and AFFINE, running a programmed number of passes per layer.
// Latency: each pass takes GAP load-low cycles, then the engine latency, then one HOLD cycle when res_ready is high.
// Backpressure: while res_ready is low the pass stays in HOLD, and dot_load, the engine result and all tags stay frozen.
//
// Optional feature: define DOT_SCHED_TIMEOUT_EN to abort the whole sequence when a pass
// waits TIMEOUT cycles in RUN without dot_valid. In that case err is set and done pulses.
//
// Ports:
//   clk        in   1  clock; all logic updates on posedge
//   rst_n      in   1  synchronous active-low reset
//   start      in   1  1-cycle pulse that begins the full layer sequence (ignored while busy)
//   busy       out  1  high from the accepted start until the cycle after done
//   done       out  1  1-cycle pulse after the last AFFINE result is accepted, or on abort
//   err        out  1  sticky timeout flag, cleared by the next accepted start
//   cs_layer   out  4  layer code driven to the engine
//   dot_load   out  1  engine load; high through RUN and HOLD
//   dot_valid  in   1  engine result valid
//   pass_idx   out  6  pass number within the current layer, 0-based
//   res_valid  out  1  engine q is stable and belongs to (cs_layer, pass_idx)
//   res_ready  in   1  consumer accepts the result
module dot_sched #(
  parameter int unsigned PASSES_L0 = 32,
  parameter int unsigned PASSES_L1 = 16,
  parameter int unsigned PASSES_L2 = 8,
  parameter int unsigned PASSES_L3 = 4,
  parameter int unsigned PASSES_AF = 1,
  parameter int unsigned GAP       = 2,
  parameter int unsigned TIMEOUT   = 1023,
  // Layer codes must match the engine's layer table.
  parameter logic [3:0]  LAYER0    = 4'd0,
  parameter logic [3:0]  LAYER1    = 4'd1,
  parameter logic [3:0]  LAYER2    = 4'd2,
  parameter logic [3:0]  LAYER3    = 4'd3,
  parameter logic [3:0]  AFFINE    = 4'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] cs_layer,
  output logic       dot_load,
  input  logic       dot_valid,
  output logic [5:0] pass_idx,
  output logic       res_valid,
  input  logic       res_ready
);

  // Elaboration-time range check of the configuration.
  if (PASSES_L0 == 0 || PASSES_L0 > 63 || PASSES_L1 == 0 || PASSES_L1 > 63 ||
      PASSES_L2 == 0 || PASSES_L2 > 63 || PASSES_L3 == 0 || PASSES_L3 > 63 ||
      PASSES_AF == 0 || PASSES_AF > 63 || GAP == 0 ||
      TIMEOUT == 0 || TIMEOUT > 1023) begin : g_bad_params
    $error("dot_sched: parameter out of range");
  end

  localparam int unsigned    GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0]  GAP_INIT = GW'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_RUN   = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Returns the index of the last pass for a layer.
  function automatic logic [5:0] last_pass_of(input logic [3:0] layer);
    logic [5:0] lp;
    case (layer)
      LAYER0:  lp = 6'(PASSES_L0 - 1);
      LAYER1:  lp = 6'(PASSES_L1 - 1);
      LAYER2:  lp = 6'(PASSES_L2 - 1);
      LAYER3:  lp = 6'(PASSES_L3 - 1);
      default: lp = 6'(PASSES_AF - 1);
    endcase
    return lp;
  endfunction

  // Returns the layer that follows in the walk. AFFINE is terminal and is handled by the caller.
  function automatic logic [3:0] next_layer_of(input logic [3:0] layer);
    logic [3:0] nl;
    case (layer)
      LAYER0:  nl = LAYER1;
      LAYER1:  nl = LAYER2;
      LAYER2:  nl = LAYER3;
      default: nl = AFFINE;
    endcase
    return nl;
  endfunction

  state_t          state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [3:0]      cs_layer_q, cs_layer_d;
  logic            dot_load_q, dot_load_d;
  logic [5:0]      pass_idx_q, pass_idx_d;
  logic            res_valid_q, res_valid_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
`ifdef DOT_SCHED_TIMEOUT_EN
  localparam logic [9:0] RUN_LIMIT = 10'(TIMEOUT - 1);
  logic            err_q, err_d;
  logic [9:0]      run_cnt_q, run_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cs_layer_d  = cs_layer_q;
    dot_load_d  = dot_load_q;
    pass_idx_d  = pass_idx_q;
    res_valid_d = res_valid_q;
    gap_cnt_d   = gap_cnt_q;
`ifdef DOT_SCHED_TIMEOUT_EN
    err_d       = err_q;
    run_cnt_d   = run_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SETUP;
          busy_d     = 1'b1;
          cs_layer_d = LAYER0;
          pass_idx_d = 6'd0;
          gap_cnt_d  = GAP_INIT;
          dot_load_d = 1'b0;
`ifdef DOT_SCHED_TIMEOUT_EN
          err_d      = 1'b0;
`endif
        end
      end

      // Load stays low for exactly GAP cycles so the engine can reload its ROM offset.
      S_SETUP: begin
        if (gap_cnt_q == '0) begin
          state_d    = S_RUN;
          dot_load_d = 1'b1;
`ifdef DOT_SCHED_TIMEOUT_EN
          run_cnt_d  = 10'd0;
`endif
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end

      S_RUN: begin
        if (dot_valid) begin
          // Load stays high, because the engine drops q and valid as soon as load falls.
          state_d     = S_HOLD;
          res_valid_d = 1'b1;
        end
`ifdef DOT_SCHED_TIMEOUT_EN
        else if (run_cnt_q == RUN_LIMIT) begin
          // Abort the whole sequence. The remaining layers are not run.
          state_d    = S_DONE;
          done_d     = 1'b1;
          err_d      = 1'b1;
          dot_load_d = 1'b0;
        end else begin
          run_cnt_d = run_cnt_q + 10'd1;
        end
`endif
      end

      S_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          dot_load_d  = 1'b0;
          if (pass_idx_q < last_pass_of(cs_layer_q)) begin
            state_d    = S_SETUP;
            pass_idx_d = pass_idx_q + 6'd1;
            gap_cnt_d  = GAP_INIT;
          end else if (cs_layer_q != AFFINE) begin
            // The layer changes only here, on the SETUP entry edge, while load is falling.
            state_d    = S_SETUP;
            cs_layer_d = next_layer_of(cs_layer_q);
            pass_idx_d = 6'd0;
            gap_cnt_d  = GAP_INIT;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cs_layer_q  <= LAYER0;
      dot_load_q  <= 1'b0;
      pass_idx_q  <= 6'd0;
      res_valid_q <= 1'b0;
      gap_cnt_q   <= '0;
`ifdef DOT_SCHED_TIMEOUT_EN
      err_q       <= 1'b0;
      run_cnt_q   <= 10'd0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cs_layer_q  <= cs_layer_d;
      dot_load_q  <= dot_load_d;
      pass_idx_q  <= pass_idx_d;
      res_valid_q <= res_valid_d;
      gap_cnt_q   <= gap_cnt_d;
`ifdef DOT_SCHED_TIMEOUT_EN
      err_q       <= err_d;
      run_cnt_q   <= run_cnt_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign cs_layer  = cs_layer_q;
  assign dot_load  = dot_load_q;
  assign pass_idx  = pass_idx_q;
  assign res_valid = res_valid_q;
`ifdef DOT_SCHED_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule
